// File: rtl/crc_sequencer_if.sv
// Register-side bus between the APB slave decoder and the CRC sequencer.
interface crc_sequencer_if #(
  parameter int WORD_SIZE = 32
);
  typedef logic [2:0] regsel_t;

  logic                 write_enable;
  regsel_t              register_select;
  logic [WORD_SIZE-1:0] write_data;
  logic [WORD_SIZE-1:0] read_data;

  modport master (
    output write_enable,
    output register_select,
    output write_data,
    input  read_data
  );

  modport slave (
    input  write_enable,
    input  register_select,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/crc_sequencer.sv
// Feeds words queued through CRC_INPUT into a byte-wide CRC datapath, MSB byte first.
// Optional: define CRC_OVERFLOW_IRQ_EN to drive irq from the overflow/done flags.
module crc_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WORD_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_sequencer_if.slave       bus,
  output logic                 crc_init,
  output logic                 crc_byte_valid,
  output logic [7:0]           crc_byte,
  input  logic [WORD_SIZE-1:0] crc_result,
  output logic                 irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] SEL_CONTROL = 3'd0;
  localparam logic [2:0] SEL_STATUS  = 3'd1;
  localparam logic [2:0] SEL_INPUT   = 3'd2;
  localparam logic [2:0] SEL_OUTPUT  = 3'd3;

  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           byte_cnt;
  logic [1:0]           byte_cnt_next;
  logic [WORD_SIZE-1:0] shift_reg;
  logic [WORD_SIZE-1:0] shift_next;

  logic [WORD_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;

  logic overflow;
  logic done;
  logic fifo_empty;
  logic fifo_full;
  logic busy;
  logic clear;
  logic input_write;
  logic push;
  logic pop;
  logic finish_word;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == FULL_COUNT);
  assign busy        = (state == SHIFT) || !fifo_empty;
  assign clear       = bus.write_enable && (bus.register_select == SEL_CONTROL) && bus.write_data[0];
  assign input_write = bus.write_enable && (bus.register_select == SEL_INPUT);
  // Fullness is judged at the start of the cycle, so a same-cycle pop never frees a slot.
  assign push        = input_write && !fifo_full;

  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    shift_next    = shift_reg;
    pop           = 1'b0;
    finish_word   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          shift_next    = fifo_mem[rd_ptr];
          byte_cnt_next = 2'd0;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        shift_next    = shift_reg << 8;
        byte_cnt_next = byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          if (!fifo_empty) begin
            pop           = 1'b1;
            shift_next    = fifo_mem[rd_ptr];
            byte_cnt_next = 2'd0;
          end else begin
            state_next  = IDLE;
            finish_word = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      byte_cnt  <= 2'd0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      byte_cnt  <= byte_cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Done is cleared only by a push that lands while idle, never by one queued mid-stream.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (input_write && fifo_full) begin
        overflow <= 1'b1;
      end
      if (finish_word) begin
        done <= 1'b1;
      end else if (push && (state == IDLE)) begin
        done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_init <= 1'b0;
    end else begin
      crc_init <= clear;
    end
  end

  assign crc_byte_valid = (state == SHIFT);
  assign crc_byte       = shift_reg[WORD_SIZE-1 -: 8];

`ifdef CRC_OVERFLOW_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      irq <= 1'b0;
    end else begin
      irq <= overflow || done;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    bus.read_data = '0;
    case (bus.register_select)
      SEL_STATUS: bus.read_data[3:0] = {overflow, done, fifo_full, busy};
      SEL_OUTPUT: bus.read_data      = crc_result;
      default:    bus.read_data      = '0;
    endcase
  end

endmodule

// File: tb/tb_crc_sequencer.sv
// Directed self-checking bench for crc_sequencer with a depth-4 input FIFO.
`timescale 1ns/1ps
module tb_crc_sequencer;

  localparam int WORD_SIZE = 32;
  localparam logic [2:0] SEL_CONTROL = 3'd0;
  localparam logic [2:0] SEL_STATUS  = 3'd1;
  localparam logic [2:0] SEL_INPUT   = 3'd2;
  localparam logic [2:0] SEL_OUTPUT  = 3'd3;
  localparam logic [2:0] SEL_UNUSED  = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        crc_init;
  logic        crc_byte_valid;
  logic [7:0]  crc_byte;
  logic [31:0] crc_result;
  logic        irq;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  crc_sequencer_if #(.WORD_SIZE(WORD_SIZE)) bus ();

  crc_sequencer #(
    .FIFO_DEPTH(4),
    .WORD_SIZE (WORD_SIZE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .crc_init      (crc_init),
    .crc_byte_valid(crc_byte_valid),
    .crc_byte      (crc_byte),
    .crc_result    (crc_result),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.write_enable    = 1'b1;
    bus.register_select = SEL_INPUT;
    bus.write_data      = w;
    tick();
    bus.write_enable    = 1'b0;
  endtask

  task automatic write_ctrl(input logic [31:0] w);
    bus.write_enable    = 1'b1;
    bus.register_select = SEL_CONTROL;
    bus.write_data      = w;
    tick();
    bus.write_enable    = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] sel, output logic [31:0] v);
    bus.register_select = sel;
    #1;
    v = bus.read_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.write_enable    = 1'b0;
    bus.register_select = SEL_CONTROL;
    bus.write_data      = '0;
    crc_result          = 32'h1234_5678;
    tick();
    tick();
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", crc_byte_valid); end
    checks++; if (crc_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte got %h want 00", crc_byte); end
    checks++; if (crc_init !== 1'b0) begin errors++; $display("[TB] FAIL reset_init got %b want 0", crc_init); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_status got %h want 0", rd); end
    rst = 1'b0;
    tick();
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid got %b want 0", crc_byte_valid); end
  endtask

  task automatic test_register_reads();
    read_reg(SEL_OUTPUT, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("[TB] FAIL read_output got %h want 12345678", rd); end
    read_reg(SEL_UNUSED, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL read_unused got %h want 0", rd); end
    read_reg(SEL_CONTROL, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL read_control got %h want 0", rd); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    push(32'hA1B2_C3D4);
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_latency got %b want 0", crc_byte_valid); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL single_busy_status got %h want 1", rd); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (crc_byte_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid[%0d] got %b want 1", i, crc_byte_valid); end
      checks++; if (crc_byte !== exp_bytes[i]) begin errors++; $display("[TB] FAIL single_byte[%0d] got %h want %h", i, crc_byte, exp_bytes[i]); end
    end
    tick();
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_end_valid got %b want 0", crc_byte_valid); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("[TB] FAIL single_done_status got %h want 4", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bytes [8];
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push(32'h1122_3344);
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL b2b_done_cleared got %h want 1", rd); end
    push(32'h5566_7788);
    for (int i = 0; i < 8; i++) begin
      read_reg(SEL_STATUS, rd);
      checks++; if (crc_byte_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got %b want 1", i, crc_byte_valid); end
      checks++; if (crc_byte !== exp_bytes[i]) begin errors++; $display("[TB] FAIL b2b_byte[%0d] got %h want %h", i, crc_byte, exp_bytes[i]); end
      checks++; if (rd[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy[%0d] got %b want 1", i, rd[0]); end
      tick();
    end
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_valid got %b want 0", crc_byte_valid); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("[TB] FAIL b2b_end_status got %h want 4", rd); end
  endtask

  task automatic test_overflow();
    int         k;
    logic [7:0] exp_b;
    push(32'h0102_0304);
    push(32'h0506_0708);
    push(32'h090A_0B0C);
    push(32'h0D0E_0F10);
    push(32'h1112_1314);
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("[TB] FAIL ovf_full_status got %h want 3", rd); end
    push(32'h1516_1718);
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h9) begin errors++; $display("[TB] FAIL ovf_set_status got %h want 9", rd); end
    // Words 2..5 still stream out; the dropped sixth word must never appear.
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (crc_byte_valid === 1'b1) begin
        exp_b = 8'(5 + k);
        checks++; if (crc_byte !== exp_b) begin errors++; $display("[TB] FAIL ovf_byte[%0d] got %h want %h", k, crc_byte, exp_b); end
        k++;
      end
      tick();
    end
    checks++; if (k !== 16) begin errors++; $display("[TB] FAIL ovf_byte_count got %0d want 16", k); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'hC) begin errors++; $display("[TB] FAIL ovf_end_status got %h want c", rd); end
`ifdef CRC_OVERFLOW_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL ovf_irq got %b want 1", irq); end
`else
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ovf_irq got %b want 0", irq); end
`endif
    write_ctrl(32'h1);
    checks++; if (crc_init !== 1'b1) begin errors++; $display("[TB] FAIL ovf_clear_init got %b want 1", crc_init); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear_irq got %b want 0", irq); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL ovf_clear_status got %h want 0", rd); end
    tick();
    checks++; if (crc_init !== 1'b0) begin errors++; $display("[TB] FAIL ovf_init_pulse got %b want 0", crc_init); end
  endtask

  task automatic test_clear_mid_word();
    push(32'hCAFE_BABE);
    tick();
    checks++; if (crc_byte !== 8'hCA) begin errors++; $display("[TB] FAIL abort_byte0 got %h want ca", crc_byte); end
    tick();
    checks++; if (crc_byte !== 8'hFE) begin errors++; $display("[TB] FAIL abort_byte1 got %h want fe", crc_byte); end
    checks++; if (crc_init !== 1'b0) begin errors++; $display("[TB] FAIL abort_init_before got %b want 0", crc_init); end
    write_ctrl(32'h1);
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid got %b want 0", crc_byte_valid); end
    checks++; if (crc_init !== 1'b1) begin errors++; $display("[TB] FAIL abort_init got %b want 1", crc_init); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL abort_status got %h want 0", rd); end
    tick();
    checks++; if (crc_init !== 1'b0) begin errors++; $display("[TB] FAIL abort_init_once got %b want 0", crc_init); end
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_valid got %b want 0", crc_byte_valid); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push(32'h2021_2223);
    push(32'h2425_2627);
    push(32'h2829_2A2B);
    push(32'h2C2D_2E2F);
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL rstmid_pre_status got %h want 1", rd); end
    // Reset together with a clear: reset must win, so no crc_init pulse follows.
    rst = 1'b1;
    write_ctrl(32'h1);
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", crc_byte_valid); end
    checks++; if (crc_byte !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_byte got %h want 00", crc_byte); end
    checks++; if (crc_init !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_init got %b want 0", crc_init); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_irq got %b want 0", irq); end
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_status got %h want 0", rd); end
    rst = 1'b0;
    tick();
    checks++; if (crc_byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flushed got %b want 0", crc_byte_valid); end
    push(32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (crc_byte_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_valid[%0d] got %b want 1", i, crc_byte_valid); end
      checks++; if (crc_byte !== exp_bytes[i]) begin errors++; $display("[TB] FAIL rstmid_byte[%0d] got %h want %h", i, crc_byte, exp_bytes[i]); end
    end
    tick();
    read_reg(SEL_STATUS, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("[TB] FAIL rstmid_end_status got %h want 4", rd); end
  endtask

  initial begin
    test_reset();
    test_register_reads();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_clear_mid_word();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
